cpu_state_dumper: RTL and testbench

CPU_STATE_DUMPER -- requirements
Module: cpu_state_dumper

---
 rtl/cpu_dbg_pkg.sv | 41 ++++
 rtl/dbg_event_counter.sv | 23 ++
 rtl/cpu_state_dumper.sv | 152 +++++++++++++++
 tb/tb_cpu_state_dumper.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and word-map constants for the CPU state dump stream.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } dump_state_t;

    typedef enum logic [1:0] {
        SRC_HDR = 2'd0,
        SRC_REG = 2'd1,
        SRC_MEM = 2'd2
    } word_src_t;

    localparam int HDR_WORDS = 4;
    localparam int NUM_REGS  = 32;
    localparam int MEM_WORDS = 8;
    localparam int REG_BASE  = HDR_WORDS;
    localparam int MEM_BASE  = REG_BASE + NUM_REGS;
    localparam int NUM_WORDS = MEM_BASE + MEM_WORDS;

    localparam int IDX_W = 6;
    typedef logic [IDX_W-1:0] word_idx_t;

    localparam word_idx_t LAST_IDX = word_idx_t'(NUM_WORDS - 1);

    // Header words are snapshots, the rest are read live from the debug ports.
    function automatic word_src_t word_src(input word_idx_t idx);
        word_src_t src;
        if (idx < word_idx_t'(REG_BASE)) begin
            src = SRC_HDR;
        end else if (idx < word_idx_t'(MEM_BASE)) begin
            src = SRC_REG;
        end else begin
            src = SRC_MEM;
        end
        return src;
    endfunction

endpackage

// File: rtl/dbg_event_counter.sv
// Free-running wrapping event counter with enable and synchronous reset.
module dbg_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] value;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end
    end

    assign count = value;

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams a 44-word CPU state dump: counter/PC snapshots, then live GPRs and
// the first eight data-memory words, one word per valid/ready handshake.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | waiting for dump_req_i; snapshots taken on the accepting edge
// ST_FETCH | debug read addresses driven, selected word registered
// ST_SEND  | word presented with out_valid_o until the consumer takes it
module cpu_state_dumper
    import cpu_dbg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        dump_req_i,
    output logic [4:0]  reg_raddr_o,
    input  logic [31:0] reg_rdata_i,
    output logic [31:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [5:0]  out_index_o,
    output logic        out_last_o,
    output logic        busy_o
);

    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    dbg_event_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (1'b1),
        .count (cycle_cnt)
    );

    dbg_event_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (stall_i),
        .count (stall_cnt)
    );

    dbg_event_counter #(.WIDTH(32)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (flush_i),
        .count (flush_cnt)
    );

    dump_state_t state;
    word_idx_t   idx;
    logic [31:0] snap_cycle;
    logic [31:0] snap_stall;
    logic [31:0] snap_flush;
    logic [31:0] snap_pc;

    word_idx_t   mem_off;
    logic [31:0] fetch_word;

    // Debug read ports are combinational, so addresses only need to be valid
    // for the FETCH cycle; elsewhere they park at zero.
    always_comb begin
        mem_off     = idx - word_idx_t'(MEM_BASE);
        reg_raddr_o = '0;
        mem_raddr_o = '0;
        if (state == ST_FETCH) begin
            case (word_src(idx))
                SRC_REG: reg_raddr_o = 5'(idx - word_idx_t'(REG_BASE));
                SRC_MEM: mem_raddr_o = {24'd0, mem_off, 2'b00};
                default: ;
            endcase
        end
    end

    always_comb begin
        fetch_word = '0;
        case (word_src(idx))
            SRC_HDR: begin
                case (idx[1:0])
                    2'd0:    fetch_word = snap_cycle;
                    2'd1:    fetch_word = snap_stall;
                    2'd2:    fetch_word = snap_flush;
                    default: fetch_word = snap_pc;
                endcase
            end
            SRC_REG: fetch_word = reg_rdata_i;
            default: fetch_word = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            snap_cycle  <= '0;
            snap_stall  <= '0;
            snap_flush  <= '0;
            snap_pc     <= '0;
            out_data_o  <= '0;
            out_index_o <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                    if (dump_req_i) begin
                        snap_cycle <= cycle_cnt;
                        snap_stall <= stall_cnt;
                        snap_flush <= flush_cnt;
                        snap_pc    <= pc_i;
                        idx        <= '0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    out_data_o  <= fetch_word;
                    out_index_o <= idx;
                    out_valid_o <= 1'b1;
                    out_last_o  <= (idx == LAST_IDX);
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + word_idx_t'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench for cpu_state_dumper with a behavioural register file and memory.
module tb_cpu_state_dumper;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic        dump_req_i;
    logic [4:0]  reg_raddr_o;
    logic [31:0] reg_rdata_i;
    logic [31:0] mem_raddr_o;
    logic [31:0] mem_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [5:0]  out_index_o;
    logic        out_last_o;
    logic        busy_o;

    cpu_state_dumper dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .pc_i        (pc_i),
        .dump_req_i  (dump_req_i),
        .reg_raddr_o (reg_raddr_o),
        .reg_rdata_i (reg_rdata_i),
        .mem_raddr_o (mem_raddr_o),
        .mem_rdata_i (mem_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_index_o (out_index_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] regs [32];
    logic [31:0] mem  [8];

    always_comb reg_rdata_i = regs[reg_raddr_o];
    // Out-of-window or misaligned addresses return a poison value.
    always_comb mem_rdata_i = (mem_raddr_o[31:5] == 27'd0 && mem_raddr_o[1:0] == 2'b00)
                              ? mem[mem_raddr_o[4:2]] : 32'hBAD0_BAD0;

    int checks = 0;
    int passed = 0;

    logic [31:0] cap_data [64];
    logic [5:0]  cap_idx  [64];
    logic        cap_last [64];
    int          ncap;
    int          stab_err;
    int          first_valid;
    int          idle_edge;
    bit          timed_out;
    bit          aborted;

    function automatic logic [31:0] exp_word(input int i, input logic [31:0] c,
                                             input logic [31:0] s, input logic [31:0] f,
                                             input logic [31:0] p);
        logic [31:0] w;
        if (i == 0)      w = c;
        else if (i == 1) w = s;
        else if (i == 2) w = f;
        else if (i == 3) w = p;
        else if (i < 36) w = regs[i-4];
        else             w = mem[i-36];
        return w;
    endfunction

    task automatic apply_reset();
        rst_i       = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        dump_req_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Raises dump_req_i at a falling edge and records every handshaken word.
    // pat 0: ready always high; pat 1: ready one cycle on, two off.
    task automatic run_dump(input int pat, input bit hold, input int pulse_idx,
                            input int abort_idx, input int poke_c);
        logic [31:0] h_data;
        logic [5:0]  h_idx;
        logic        h_last;
        bit          prev_hold;
        ncap = 0; stab_err = 0; first_valid = -1; idle_edge = -1;
        timed_out = 1'b1; aborted = 1'b0; prev_hold = 1'b0;
        h_data = '0; h_idx = '0; h_last = 1'b0;
        dump_req_i  = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (!hold) dump_req_i = 1'b0;
            if (c == poke_c) begin
                regs[30] = 32'hCAFE_F00D;
                pc_i     = 32'hDEAD_0000;
            end
            if (first_valid < 0 && out_valid_o) first_valid = c;
            if (prev_hold && (out_valid_o !== 1'b1 || out_data_o !== h_data ||
                              out_index_o !== h_idx || out_last_o !== h_last))
                stab_err++;
            if (abort_idx >= 0 && out_valid_o && int'(out_index_o) == abort_idx) begin
                rst_i = 1'b1; aborted = 1'b1; timed_out = 1'b0;
                break;
            end
            if (!busy_o) begin
                idle_edge = c; timed_out = 1'b0;
                break;
            end
            if (pulse_idx >= 0 && out_valid_o && int'(out_index_o) == pulse_idx)
                dump_req_i = 1'b1;
            out_ready_i = (pat == 0) ? 1'b1 : (c % 3 == 0);
            if (out_valid_o && out_ready_i && ncap < 64) begin
                cap_data[ncap] = out_data_o;
                cap_idx[ncap]  = out_index_o;
                cap_last[ncap] = out_last_o;
                ncap++;
            end
            prev_hold = out_valid_o && !out_ready_i;
            h_data = out_data_o; h_idx = out_index_o; h_last = out_last_o;
        end
        out_ready_i = 1'b1;
        if (!hold) dump_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; dump_req_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
        out_ready_i = 1'b0; pc_i = 32'h1357_9BDF;
        repeat (3) @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid_o); else passed++;
        checks++; if (out_last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
        checks++; if (out_data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", out_data_o); else passed++;
        checks++; if (out_index_o !== 6'd0) $display("FAIL reset_index: got %0d want 0", out_index_o); else passed++;
        checks++; if (reg_raddr_o !== 5'd0) $display("FAIL reset_raddr: got %0d want 0", reg_raddr_o); else passed++;
        checks++; if (mem_raddr_o !== 32'd0) $display("FAIL reset_maddr: got %h want 0", mem_raddr_o); else passed++;
        rst_i = 1'b0; dump_req_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    endtask

    task automatic test_basic_dump();
        pc_i = 32'h0000_4000;
        apply_reset();
        repeat (10) @(negedge clk_i);
        run_dump(0, 1'b0, -1, -1, -1);
        checks++; if (timed_out !== 1'b0) $display("FAIL basic_timeout: got %b want 0", timed_out); else passed++;
        checks++; if (ncap != 44) $display("FAIL basic_count: got %0d want 44", ncap); else passed++;
        checks++; if (first_valid != 1) $display("FAIL basic_first_valid: got edge %0d want 1", first_valid); else passed++;
        checks++; if (idle_edge != 88) $display("FAIL basic_idle_edge: got %0d want 88", idle_edge); else passed++;
        for (int i = 0; i < 44; i++) begin
            checks++;
            if (cap_idx[i] !== 6'(i) || cap_data[i] !== exp_word(i, 32'd10, 32'd0, 32'd0, 32'h4000) ||
                cap_last[i] !== (i == 43))
                $display("FAIL basic_word%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, cap_idx[i], cap_data[i], cap_last[i], i,
                         exp_word(i, 32'd10, 32'd0, 32'd0, 32'h4000), (i == 43));
            else passed++;
        end
    endtask

    task automatic test_counters_and_data();
        regs[5]  = 32'h0000_1234;
        regs[30] = 32'h0000_0030;
        mem[0]   = 32'd5;
        apply_reset();
        stall_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        @(negedge clk_i);
        stall_i = 1'b0;
        pc_i = 32'h8000_0010;
        run_dump(0, 1'b0, -1, -1, 3);
        checks++; if (ncap != 44) $display("FAIL cnt_count: got %0d want 44", ncap); else passed++;
        checks++; if (cap_data[0] !== 32'd3) $display("FAIL cnt_cycle: got %h want 3", cap_data[0]); else passed++;
        checks++; if (cap_data[1] !== 32'd3) $display("FAIL cnt_stall: got %h want 3", cap_data[1]); else passed++;
        checks++; if (cap_data[2] !== 32'd2) $display("FAIL cnt_flush: got %h want 2", cap_data[2]); else passed++;
        checks++; if (cap_data[3] !== 32'h8000_0010) $display("FAIL cnt_pc_snapshot: got %h want 80000010", cap_data[3]); else passed++;
        checks++; if (cap_data[9] !== 32'h0000_1234) $display("FAIL cnt_x5: got %h want 00001234", cap_data[9]); else passed++;
        checks++; if (cap_data[34] !== 32'hCAFE_F00D) $display("FAIL cnt_x30_live: got %h want cafef00d", cap_data[34]); else passed++;
        checks++; if (cap_data[36] !== 32'd5) $display("FAIL cnt_mem0: got %h want 5", cap_data[36]); else passed++;
        checks++; if (cap_data[43] !== mem[7]) $display("FAIL cnt_mem7: got %h want %h", cap_data[43], mem[7]); else passed++;
    endtask

    task automatic test_backpressure();
        pc_i = 32'h0000_0BAD;
        apply_reset();
        repeat (7) @(negedge clk_i);
        run_dump(1, 1'b0, -1, -1, -1);
        checks++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %b want 0", timed_out); else passed++;
        checks++; if (stab_err != 0) $display("FAIL bp_stability: got %0d unstable cycles want 0", stab_err); else passed++;
        checks++; if (ncap != 44) $display("FAIL bp_count: got %0d want 44", ncap); else passed++;
        for (int i = 0; i < 44; i++) begin
            checks++;
            if (cap_idx[i] !== 6'(i) || cap_data[i] !== exp_word(i, 32'd7, 32'd0, 32'd0, 32'h0BAD) ||
                cap_last[i] !== (i == 43))
                $display("FAIL bp_word%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                         i, cap_idx[i], cap_data[i], cap_last[i], i,
                         exp_word(i, 32'd7, 32'd0, 32'd0, 32'h0BAD), (i == 43));
            else passed++;
        end
    endtask

    task automatic test_req_while_busy();
        int extra_valid;
        apply_reset();
        run_dump(0, 1'b0, 10, -1, -1);
        checks++; if (ncap != 44) $display("FAIL busy_pulse_count: got %0d want 44", ncap); else passed++;
        checks++; if (idle_edge != 88) $display("FAIL busy_pulse_idle: got %0d want 88", idle_edge); else passed++;
        extra_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (busy_o || out_valid_o) extra_valid++;
        end
        checks++; if (extra_valid != 0) $display("FAIL busy_pulse_queued: got %0d busy cycles want 0", extra_valid); else passed++;

        apply_reset();
        run_dump(0, 1'b1, -1, -1, -1);
        checks++; if (idle_edge != 88) $display("FAIL hold_idle: got %0d want 88", idle_edge); else passed++;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) $display("FAIL hold_restart_busy: got %b want 1", busy_o); else passed++;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_index_o !== 6'd0)
            $display("FAIL hold_restart_word: got valid %b idx %0d want valid 1 idx 0", out_valid_o, out_index_o);
        else passed++;
        dump_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        int late_valid;
        apply_reset();
        stall_i = 1'b1;
        run_dump(0, 1'b0, -1, 20, -1);
        stall_i = 1'b0;
        checks++; if (aborted !== 1'b1) $display("FAIL abort_reached: got %b want 1", aborted); else passed++;
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_o); else passed++;
        checks++; if (out_index_o !== 6'd0) $display("FAIL abort_index: got %0d want 0", out_index_o); else passed++;
        rst_i = 1'b0;
        late_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (out_valid_o || busy_o) late_valid++;
        end
        checks++; if (late_valid != 0) $display("FAIL abort_resumed: got %0d active cycles want 0", late_valid); else passed++;
        run_dump(0, 1'b0, -1, -1, -1);
        checks++; if (ncap != 44) $display("FAIL abort_redump_count: got %0d want 44", ncap); else passed++;
        checks++; if (cap_idx[0] !== 6'd0) $display("FAIL abort_redump_idx0: got %0d want 0", cap_idx[0]); else passed++;
        checks++; if (cap_data[0] !== 32'd5) $display("FAIL abort_redump_cycle: got %h want 5", cap_data[0]); else passed++;
        checks++; if (cap_data[1] !== 32'd0) $display("FAIL abort_redump_stall: got %h want 0", cap_data[1]); else passed++;
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.u_cycle_cnt.value = 32'hFFFF_FFFE;
        #1;
        release dut.u_cycle_cnt.value;
        repeat (3) @(negedge clk_i);
        run_dump(0, 1'b0, -1, -1, -1);
        checks++; if (cap_data[0] !== 32'h0000_0001) $display("FAIL wrap_cycle: got %h want 00000001", cap_data[0]); else passed++;
        checks++; if (cap_data[1] !== 32'd0) $display("FAIL wrap_stall: got %h want 0", cap_data[1]); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; dump_req_i = 1'b0;
        out_ready_i = 1'b1; pc_i = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h11;
        regs[0] = 32'd0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h2000_0000 + i * 32'h101;
        test_reset();
        test_basic_dump();
        test_counters_and_data();
        test_backpressure();
        test_req_while_busy();
        test_reset_mid_dump();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
